bcd_to_ex3_seq: RTL and testbench
=================================

// Module: bcd_to_ex3_seq
//
// PURPOSE
//   Sequencing controller for multi-digit BCD to Excess-3 conversion. Accepts a
//   packed DIGITS-wide BCD word over a valid/ready handshake. Feeds one digit per
//   cycle, least significant digit first, through a single internal bcd_to_ex3
//   instance, then presents the packed Excess-3 word and a per-digit error mask
//   on an output valid/ready handshake. Sits between the BCD source and any
//   Excess-3 consumer, so wide words reuse one 4-bit converter.
//
// PARAMETERS
//   DIGITS   4   number of BCD digits per word (>=1); word width = 4*DIGITS
//
// PORTS
//   clk           in   1         rising-edge clock
//   rst           in   1         synchronous, active-high reset
//   in_valid      in   1         in_bcd is valid
//   in_ready      out  1         block can accept a word (combinational: state==IDLE && !rst)
//   in_bcd        in   4*DIGITS  packed BCD; digit i = in_bcd[4i+3:4i]
//   out_valid     out  1         out_ex3/out_err_mask valid (registered)
//   out_ready     in   1         consumer accepts the output word
//   out_ex3       out  4*DIGITS  packed Excess-3 result; digit i = out_ex3[4i+3:4i]
//   out_err_mask  out  DIGITS    bit i set: input digit i was >9
//   out_err       out  1         |out_err_mask
//   busy          out  1         state != IDLE
//
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): state=IDLE, digit index=0, out_valid=0,
//     out_ex3=0, out_err_mask=0, and the captured input register is cleared.
//     in_ready is 0 while rst is high. Reset wins over every other event, including
//     mid-CONV and DONE. Any word in flight is discarded and no output is produced.
//   - FSM states: IDLE, CONV, DONE.
//   - IDLE: in_ready=1. On in_valid&&in_ready:
//       - capture in_bcd;
//       - clear out_ex3 and out_err_mask;
//       - set idx=0;
//       - go to CONV.
//   - CONV: in_ready=0, and in_valid is ignored. Each cycle, digit idx of the
//     captured word drives the converter. At the edge, result digit idx is written:
//       - digit<=9: ex3 = digit+3 (converter output);
//       - digit>=10: result digit forced to 4'h0 and out_err_mask[idx] set.
//     Then idx increments. The edge that writes idx==DIGITS-1 moves to DONE and sets out_valid=1.
//   - Latency: input handshake at edge k gives out_valid=1 after edge k+DIGITS.
//     One word is in flight at a time; there is no pipelining.
//   - DONE: out_valid=1. out_ex3, out_err_mask and out_err are held stable while
//     out_ready=0, with no limit on the stall. On out_valid&&out_ready: out_valid->0,
//     state->IDLE. in_ready is first high in the following cycle; there is no
//     same-cycle re-accept.
//   - Output registers keep the last result after the DONE handshake until the next
//     capture clears them.
//   - The converter is purely combinational; all outputs except in_ready are registered.
//   - idx width is clog2(DIGITS) (min 1). With DIGITS=1, CONV lasts exactly one cycle.
//
// TESTING
//   1. Hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_ex3=0, busy=0;
//      no capture occurs.
//   2. DIGITS=4, in_bcd=16'h1234 accepted at edge k -> out_valid rises after edge k+4;
//      out_ex3=16'h4567, out_err_mask=4'b0000, out_err=0.
//   3. in_bcd=16'h9080 -> out_ex3=16'hC3B3, mask 0. in_bcd=16'h12A4 -> out_ex3=16'h4507,
//      out_err_mask=4'b0010, out_err=1.
//   4. Backpressure: out_ready=0 for 6 cycles in DONE -> out_ex3 and mask are stable,
//      in_ready=0; in_valid pulses are ignored. out_ready=1 -> IDLE, in_ready=1 the next cycle.
//   5. rst asserted on the 2nd CONV cycle -> IDLE next edge, out_valid never rises.
//      The next word 16'h0000 -> out_ex3=16'h3333.
//   6. Back-to-back: in_valid=1 constantly, out_ready=1, words 16'h0009 then 16'h5555 ->
//      outputs 16'h333C then 16'h8888; out_valid pulses are 6 cycles apart (4 CONV + DONE + IDLE).

Source files
------------

// File: rtl/bcd_to_ex3_seq.sv
// bcd_to_ex3 / bcd_to_ex3_seq
//
// bcd_to_ex3: purely combinational single-digit BCD to Excess-3 converter.
//   bcd  in  4  BCD digit
//   ex3  out 4  bcd + 3 (meaningful only when err=0)
//   err  out 1  digit is not valid BCD (>9)
//
// bcd_to_ex3_seq: converts a packed DIGITS-wide BCD word one digit per cycle,
// least significant digit first, through a single bcd_to_ex3 instance.
//   clk           in   1         rising-edge clock
//   rst           in   1         synchronous, active-high reset
//   in_valid      in   1         in_bcd is valid
//   in_ready      out  1         word can be accepted (IDLE and not in reset)
//   in_bcd        in   4*DIGITS  packed BCD, digit i = in_bcd[4i+3:4i]
//   out_valid     out  1         result valid (registered)
//   out_ready     in   1         consumer accepts the result
//   out_ex3       out  4*DIGITS  packed Excess-3, invalid digits forced to 0
//   out_err_mask  out  DIGITS    bit i set when input digit i was >9
//   out_err       out  1         any digit invalid
//   busy          out  1         a word is being converted or presented

module bcd_to_ex3 (
  input  logic [3:0] bcd,
  output logic [3:0] ex3,
  output logic       err
);

  always_comb begin
    err = (bcd > 4'd9);
    ex3 = bcd + 4'd3;
  end

endmodule

module bcd_to_ex3_seq #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_ex3,
  output logic [DIGITS-1:0]     out_err_mask,
  output logic                  out_err,
  output logic                  busy
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned W  = 4 * DIGITS;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] idx;
  logic [W-1:0]  cap;
  logic [3:0]    digit;
  logic [3:0]    conv_ex3;
  logic          conv_err;
  logic          accept;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign out_err  = |out_err_mask;

  // Select the digit currently being converted from the captured word.
  always_comb begin
    digit = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) digit = cap[4*i +: 4];
    end
  end

  bcd_to_ex3 u_conv (
    .bcd (digit),
    .ex3 (conv_ex3),
    .err (conv_err)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CONV;
      CONV: if (idx == LAST) state_next = DONE;
      DONE: if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      cap          <= '0;
      out_valid    <= 1'b0;
      out_ex3      <= '0;
      out_err_mask <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            cap          <= in_bcd;
            out_ex3      <= '0;
            out_err_mask <= '0;
            idx          <= '0;
          end
        end
        CONV: begin
          // Invalid digits are written as 0 and flagged in the mask.
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
              out_ex3[4*i +: 4] <= conv_err ? 4'h0 : conv_ex3;
              out_err_mask[i]   <= conv_err;
            end
          end
          idx <= idx + 1'b1;
          if (idx == LAST) out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_ex3_seq.sv
module tb_bcd_to_ex3_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ex3;
  logic [3:0]  out_err_mask;
  logic        out_err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_to_ex3_seq #(.DIGITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bcd       (in_bcd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ex3      (out_ex3),
    .out_err_mask (out_err_mask),
    .out_err      (out_err),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_bcd = 16'h1234; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      n_cmp++; if (out_ex3 !== 16'h0000) begin n_err++; $display("FAIL reset_out_ex3 got=%h want=0000", out_ex3); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got=%b want=0", busy); end
  endtask

  // Sends one word, checks the DIGITS-cycle latency and the presented result, then drains it.
  task automatic test_convert_word(input logic [15:0] bcd, input logic [15:0] exp_ex3,
                                   input logic [3:0] exp_mask, input string name);
    int lat;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_in_ready got=%b want=1", name, in_ready); end
    in_valid = 1'b1; in_bcd = bcd; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; in_bcd = 16'hFFFF;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s_busy got=%b want=1", name, busy); end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    n_cmp++; if (lat != 4) begin n_err++; $display("FAIL %s_latency got=%0d want=4", name, lat); end
    n_cmp++; if (out_ex3 !== exp_ex3) begin n_err++; $display("FAIL %s_ex3 got=%h want=%h", name, out_ex3, exp_ex3); end
    n_cmp++; if (out_err_mask !== exp_mask) begin n_err++; $display("FAIL %s_mask got=%b want=%b", name, out_err_mask, exp_mask); end
    n_cmp++; if (out_err !== (exp_mask != 4'b0)) begin n_err++; $display("FAIL %s_err got=%b want=%b", name, out_err, exp_mask != 4'b0); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_drain_valid got=%b want=0", name, out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_drain_in_ready got=%b want=1", name, in_ready); end
    n_cmp++; if (out_ex3 !== exp_ex3) begin n_err++; $display("FAIL %s_hold_ex3 got=%h want=%h", name, out_ex3, exp_ex3); end
  endtask

  task automatic test_backpressure();
    int guard;
    in_valid = 1'b1; in_bcd = 16'h1234; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 20) begin tick(); guard++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_reach_done got=%b want=1", out_valid); end
    for (int c = 0; c < 6; c++) begin
      in_valid = c[0]; in_bcd = 16'h9999;
      tick();
      n_cmp++; if (out_ex3 !== 16'h4567) begin n_err++; $display("FAIL bp_ex3 got=%h want=4567", out_ex3); end
      n_cmp++; if (out_err_mask !== 4'b0000) begin n_err++; $display("FAIL bp_mask got=%b want=0000", out_err_mask); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_release_busy got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_conv();
    int seen;
    in_valid = 1'b1; in_bcd = 16'h1234; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_cmp++; if (out_ex3 !== 16'h0000) begin n_err++; $display("FAIL midrst_ex3 got=%h want=0000", out_ex3); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midrst_no_output got=%0d want=0", seen); end
    test_convert_word(16'h0000, 16'h3333, 4'b0000, "after_rst");
  endtask

  task automatic test_back_to_back();
    int cyc;
    int first_t;
    int second_t;
    int n_out;
    in_valid = 1'b1; in_bcd = 16'h0009; out_ready = 1'b1;
    tick();
    in_bcd = 16'h5555;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_first_capture got=%b want=1", busy); end
    first_t = -1; second_t = -1; n_out = 0;
    for (cyc = 1; cyc <= 30 && n_out < 2; cyc++) begin
      tick();
      if (out_valid === 1'b1) begin
        if (n_out == 0) begin
          first_t = cyc;
          n_cmp++; if (out_ex3 !== 16'h333C) begin n_err++; $display("FAIL b2b_word0 got=%h want=333c", out_ex3); end
        end else begin
          second_t = cyc;
          n_cmp++; if (out_ex3 !== 16'h8888) begin n_err++; $display("FAIL b2b_word1 got=%h want=8888", out_ex3); end
        end
        n_out++;
      end
    end
    n_cmp++; if (first_t != 4) begin n_err++; $display("FAIL b2b_first_time got=%0d want=4", first_t); end
    n_cmp++; if (second_t - first_t != 6) begin n_err++; $display("FAIL b2b_spacing got=%0d want=6", second_t - first_t); end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
    #1;
    test_reset();
    test_convert_word(16'h1234, 16'h4567, 4'b0000, "w1234");
    test_convert_word(16'h9080, 16'hC3B3, 4'b0000, "w9080");
    test_convert_word(16'h12A4, 16'h4507, 4'b0010, "w12a4");
    test_convert_word(16'hF9A0, 16'h0C03, 4'b1010, "wf9a0");
    test_backpressure();
    test_reset_mid_conv();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
